// File: rtl/alu_exec_seq_pkg.sv
`default_nettype none
// alu_exec_seq_pkg : control codes, ALU-class codes and FSM states (rev 1.0)
package alu_exec_seq_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_BEQ   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_XOR   = 4'b0110;
    localparam logic [3:0] ALU_SLTU  = 4'b0111;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_SRA   = 4'b1010;
    localparam logic [3:0] ALU_MUL   = 4'b1011;
    localparam logic [3:0] ALU_MULHU = 4'b1100;
    localparam logic [3:0] ALU_DIVU  = 4'b1101;
    localparam logic [3:0] ALU_REMU  = 4'b1110;
    localparam logic [3:0] ALU_ILL   = 4'b1111;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_RI  = 2'b10;

    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_exec_seq_mdu_iter.sv
`default_nettype none
// alu_mdu_iter : iterative unsigned shift-add multiplier / restoring divider (rev 1.0)
module alu_mdu_iter
    import alu_exec_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_div,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic            busy;
    logic            div_mode;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] opnd;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_take;

    // hi:lo is the product register for MUL and remainder:quotient for DIV
    assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    // a zero divisor always "subtracts", giving all-ones quotient and remainder = dividend
    assign div_take  = !div_diff[XLEN] || (opnd == '0);

    // hi/lo present the post-step value so the final step lands in the caller's register
    always_comb begin
        hi = acc_hi;
        lo = acc_lo;
        if (div_mode) begin
            hi = div_take ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo = {acc_lo[XLEN-2:0], div_take};
        end else begin
            hi = mul_sum[XLEN:1];
            lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    assign done = busy && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            div_mode <= 1'b0;
            cnt      <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            div_mode <= is_div;
            cnt      <= '0;
            opnd     <= is_div ? b : a;
            acc_hi   <= '0;
            acc_lo   <= is_div ? a : b;
        end else if (busy) begin
            acc_hi <= hi;
            acc_lo <= lo;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_exec_seq.sv
`default_nettype none
// alu_exec_seq : ALU control decode, single-cycle ALU, iterative M-ops, registered result (rev 1.0)
module alu_exec_seq
    import alu_exec_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter bit M_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            op,
    input  logic [6:0]      f7,
    input  logic [2:0]      f3,
    input  logic [1:0]      aluOp,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [3:0]      alu_control,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    state_t          state;
    logic [3:0]      dec_ctrl;
    logic [XLEN-1:0] alu_res;
    logic            accept;
    logic            dec_mul;
    logic            dec_div;
    logic            mdu_done;
    logic [XLEN-1:0] mdu_hi;
    logic [XLEN-1:0] mdu_lo;
    logic [XLEN-1:0] mdu_res;
    logic [SHW-1:0]  shamt;

    always_comb begin
        dec_ctrl = ALU_ILL;
        case (aluOp)
            ALUOP_ADD: dec_ctrl = ALU_ADD;
            ALUOP_BR: begin
                case (f3)
                    3'b000:          dec_ctrl = ALU_BEQ;
                    3'b001:          dec_ctrl = ALU_SUB;
                    3'b100, 3'b101:  dec_ctrl = ALU_SLT;
                    3'b110, 3'b111:  dec_ctrl = ALU_SLTU;
                    default:         dec_ctrl = ALU_ILL;
                endcase
            end
            ALUOP_RI: begin
                // with M_EN=0 the M-extension encodings stay illegal rather than aliasing base ops
                if (op && f7 == F7_MEXT) begin
                    if (M_EN) begin
                        case (f3)
                            3'b000:  dec_ctrl = ALU_MUL;
                            3'b011:  dec_ctrl = ALU_MULHU;
                            3'b101:  dec_ctrl = ALU_DIVU;
                            3'b111:  dec_ctrl = ALU_REMU;
                            default: dec_ctrl = ALU_ILL;
                        endcase
                    end
                end else begin
                    case (f3)
                        3'b000:  dec_ctrl = (op && f7[5]) ? ALU_SUB : ALU_ADD;
                        3'b001:  dec_ctrl = ALU_SLL;
                        3'b010:  dec_ctrl = ALU_SLT;
                        3'b011:  dec_ctrl = ALU_SLTU;
                        3'b100:  dec_ctrl = ALU_XOR;
                        3'b101:  dec_ctrl = f7[5] ? ALU_SRA : ALU_SRL;
                        3'b110:  dec_ctrl = ALU_OR;
                        default: dec_ctrl = ALU_AND;
                    endcase
                end
            end
            default: dec_ctrl = ALU_ILL;
        endcase
    end

    assign shamt = src_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (dec_ctrl)
            ALU_ADD:  alu_res = src_a + src_b;
            ALU_SUB:  alu_res = src_a - src_b;
            ALU_AND:  alu_res = src_a & src_b;
            ALU_OR:   alu_res = src_a | src_b;
            ALU_BEQ:  alu_res = src_a - src_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            ALU_SLL:  alu_res = src_a << shamt;
            ALU_SRL:  alu_res = src_a >> shamt;
            ALU_SRA:  alu_res = $signed(src_a) >>> shamt;
            default:  alu_res = '0;
        endcase
    end

    assign accept  = in_valid && in_ready;
    assign dec_mul = (dec_ctrl == ALU_MUL)  || (dec_ctrl == ALU_MULHU);
    assign dec_div = (dec_ctrl == ALU_DIVU) || (dec_ctrl == ALU_REMU);
    // held control selects which half of the MDU register pair is the answer
    assign mdu_res = ((alu_control == ALU_MULHU) || (alu_control == ALU_REMU)) ? mdu_hi : mdu_lo;

    alu_mdu_iter #(
        .XLEN (XLEN)
    ) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && (dec_mul || dec_div)),
        .is_div (dec_div),
        .a      (src_a),
        .b      (src_b),
        .done   (mdu_done),
        .hi     (mdu_hi),
        .lo     (mdu_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b1;
            alu_control <= ALU_ADD;
            illegal     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_control <= dec_ctrl;
                        illegal     <= (dec_ctrl == ALU_ILL);
                        in_ready    <= 1'b0;
                        if (dec_mul) begin
                            state <= S_MUL;
                        end else if (dec_div) begin
                            state <= S_DIV;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (mdu_done) begin
                        result    <= mdu_res;
                        zero      <= (mdu_res == '0);
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_seq.sv
`default_nettype none
// tb_alu_exec_seq : directed self-checking bench for alu_exec_seq (rev 1.0)
module tb_alu_exec_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic [6:0]  f7 = '0;
    logic [2:0]  f3 = '0;
    logic [1:0]  aluOp = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;
    logic [3:0]  alu_control;
    logic        illegal;

    int n_asserts = 0;
    int n_fail = 0;
    int lat;

    alu_exec_seq #(.XLEN(32), .M_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .f7          (f7),
        .f3          (f3),
        .aluOp       (aluOp),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .alu_control (alu_control),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic o, input logic [6:0] s7, input logic [2:0] s3,
                         input logic [1:0] ao, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        op = o; f7 = s7; f3 = s3; aluOp = ao; src_a = a; src_b = b;
        step();
        in_valid = 1'b0;
        op = 1'b0; f7 = '0; f3 = '0; aluOp = '0; src_a = 32'hDEADBEEF; src_b = 32'h0BADF00D;
    endtask

    // lat counts cycles from the accepting edge; 1 means the cycle right after accept
    task automatic wait_valid(output int n);
        n = 1;
        while (out_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic do_op(input string tag, input logic o, input logic [6:0] s7,
                         input logic [2:0] s3, input logic [1:0] ao,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [3:0] exp_ctrl, input int exp_lat);
        int n;
        issue(o, s7, s3, ao, a, b);
        wait_valid(n);
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_ctl"}, 32'(alu_control), 32'(exp_ctrl));
        chk({tag, "_zero"}, 32'(zero), 32'(exp_res == 32'h0));
        chk({tag, "_ill"}, 32'(illegal), 32'(exp_ctrl == 4'hF));
        chk({tag, "_busy"}, 32'(in_ready), 32'h0);
        step();
        chk({tag, "_idle"}, 32'(in_ready), 32'h1);
        chk({tag, "_ovclr"}, 32'(out_valid), 32'h0);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", 32'(zero), 32'h1);
        chk("rst_ctl", 32'(alu_control), 32'h0);
        chk("rst_ill", 32'(illegal), 32'h0);
        rst_n = 1'b1;
        step();

        // single-cycle operations
        do_op("sub",  1'b1, 7'b0100000, 3'b000, 2'b10, 32'd5, 32'd7, 32'hFFFFFFFE, 4'b0001, 1);
        do_op("beq",  1'b0, 7'b0000000, 3'b000, 2'b01, 32'h1234, 32'h1234, 32'h0, 4'b0100, 1);
        do_op("sltu", 1'b0, 7'b0000000, 3'b110, 2'b01, 32'h1, 32'hFFFFFFFF, 32'h1, 4'b0111, 1);
        do_op("slt",  1'b1, 7'b0000000, 3'b010, 2'b10, 32'hFFFFFFFF, 32'h1, 32'h1, 4'b0101, 1);
        do_op("sra",  1'b1, 7'b0100000, 3'b101, 2'b10, 32'h80000000, 32'h4, 32'hF8000000, 4'b1010, 1);
        do_op("srl",  1'b1, 7'b0000000, 3'b101, 2'b10, 32'h80000000, 32'h4, 32'h08000000, 4'b1001, 1);
        do_op("sll",  1'b1, 7'b0000000, 3'b001, 2'b10, 32'h1, 32'h23, 32'h8, 4'b1000, 1);
        do_op("addi", 1'b0, 7'b0100000, 3'b000, 2'b10, 32'h10, 32'h3, 32'h13, 4'b0000, 1);
        do_op("add",  1'b0, 7'b0000000, 3'b111, 2'b00, 32'hFFFFFFFF, 32'h2, 32'h1, 4'b0000, 1);
        do_op("xor",  1'b1, 7'b0000000, 3'b100, 2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 4'b0110, 1);
        do_op("and",  1'b1, 7'b0000000, 3'b111, 2'b10, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010, 1);

        // iterative multiply / divide
        do_op("mul",   1'b1, 7'b0000001, 3'b000, 2'b10, 32'h10000, 32'h10000, 32'h0, 4'b1011, 33);
        do_op("mulhu", 1'b1, 7'b0000001, 3'b011, 2'b10, 32'h10000, 32'h10000, 32'h1, 4'b1100, 33);
        do_op("mul76", 1'b1, 7'b0000001, 3'b000, 2'b10, 32'd7, 32'd6, 32'd42, 4'b1011, 33);
        do_op("divu",  1'b1, 7'b0000001, 3'b101, 2'b10, 32'd100, 32'd7, 32'd14, 4'b1101, 33);
        do_op("remu",  1'b1, 7'b0000001, 3'b111, 2'b10, 32'd100, 32'd7, 32'd2, 4'b1110, 33);
        do_op("divu0", 1'b1, 7'b0000001, 3'b101, 2'b10, 32'd100, 32'd0, 32'hFFFFFFFF, 4'b1101, 33);
        do_op("remu0", 1'b1, 7'b0000001, 3'b111, 2'b10, 32'd100, 32'd0, 32'd100, 4'b1110, 33);

        // back-pressure: result held, new offers ignored
        out_ready = 1'b0;
        issue(1'b0, 7'b0, 3'b000, 2'b00, 32'd3, 32'd4);
        in_valid = 1'b1; aluOp = 2'b00; src_a = 32'd100; src_b = 32'd200;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(out_valid), 32'h1);
            chk("hold_res", result, 32'd7);
            chk("hold_ready", 32'(in_ready), 32'h0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("hold_release_ready", 32'(in_ready), 32'h1);
        chk("hold_release_ov", 32'(out_valid), 32'h0);
        chk("hold_release_res", result, 32'd7);

        // reset in the middle of a division
        out_ready = 1'b1;
        issue(1'b1, 7'b0000001, 3'b101, 2'b10, 32'd1000, 32'd3);
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_ov", 32'(out_valid), 32'h0);
        chk("midrst_ready", 32'(in_ready), 32'h1);
        chk("midrst_res", result, 32'h0);
        step();
        rst_n = 1'b1;
        repeat (40) step();
        chk("postrst_ov", 32'(out_valid), 32'h0);
        chk("postrst_ready", 32'(in_ready), 32'h1);

        // undefined encodings
        do_op("ill_op11", 1'b1, 7'b0000000, 3'b000, 2'b11, 32'd5, 32'd6, 32'h0, 4'b1111, 1);
        do_op("ill_br010", 1'b0, 7'b0000000, 3'b010, 2'b01, 32'd5, 32'd6, 32'h0, 4'b1111, 1);
        do_op("ill_m001", 1'b1, 7'b0000001, 3'b001, 2'b10, 32'd5, 32'd6, 32'h0, 4'b1111, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
